// File: rtl/sdram_arbiter.sv
// Two-port SDRAM arbiter: video read port A, CPU read/write port B, and periodic refresh,
// multiplexed onto a single-command SDRAM controller with fixed priority refresh > A > B.
module sdram_arbiter #(
    parameter int FREQ       = 54_000_000,
    parameter int REFRESH_US = 15
) (
    input  logic        clk,
    input  logic        resetn,

    input  logic        a_req,
    input  logic [22:0] a_addr,
    output logic        a_ack,
    output logic        a_valid,
    output logic [15:0] a_dout,

    input  logic        b_req,
    input  logic        b_we,
    input  logic [22:0] b_addr,
    input  logic [15:0] b_din,
    input  logic [1:0]  b_wdm,
    output logic        b_ack,
    output logic        b_valid,
    output logic [15:0] b_dout,

    output logic        sd_rd,
    output logic        sd_wr,
    output logic        sd_refresh,
    output logic [22:0] sd_addr,
    output logic [15:0] sd_din,
    output logic [1:0]  sd_wdm,
    input  logic [15:0] sd_dout,
    input  logic        sd_data_ready,
    input  logic        sd_busy
);

    localparam int RI = FREQ / 1_000_000 * REFRESH_US;
    localparam int CW = (RI > 1) ? $clog2(RI) : 1;
    localparam logic [CW-1:0] RI_LAST = CW'(RI - 1);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_CMD       = 2'd1,
        ST_WAIT_BUSY = 2'd2,
        ST_WAIT_DONE = 2'd3
    } state_t;

    state_t          state_q;
    logic [CW-1:0]   ref_cnt_q;
    logic [CW-1:0]   ref_cnt_d;
    logic            ref_pend_q;
    logic            ref_pend_d;
    logic            ref_wrap_s;
    logic            ref_req_s;
    logic            ref_grant_s;
    logic            rd_xact_q;
    logic            owner_b_q;
    logic            capture_s;

    // A wrap in the same cycle as a grant decision already counts as a pending refresh.
    assign ref_wrap_s  = (ref_cnt_q == RI_LAST);
    assign ref_req_s   = ref_pend_q | ref_wrap_s;
    assign ref_grant_s = (state_q == ST_IDLE) & ~sd_busy & ref_req_s;
    assign capture_s   = ((state_q == ST_WAIT_BUSY) || (state_q == ST_WAIT_DONE))
                         & rd_xact_q & sd_data_ready;

    // Refresh counter next state and single-deep pending flag.
    always_comb begin
        ref_cnt_d  = ref_cnt_q;
        ref_pend_d = ref_pend_q;
        if (ref_wrap_s) begin
            ref_cnt_d = {CW{1'b0}};
        end else begin
            ref_cnt_d = ref_cnt_q + {{(CW-1){1'b0}}, 1'b1};
        end
        if (ref_grant_s) begin
            ref_pend_d = 1'b0;
        end else begin
            ref_pend_d = ref_req_s;
        end
    end

    // Refresh counter and pending registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ref_cnt_q  <= {CW{1'b0}};
            ref_pend_q <= 1'b0;
        end else begin
            ref_cnt_q  <= ref_cnt_d;
            ref_pend_q <= ref_pend_d;
        end
    end

    // Arbitration FSM with registered command, ack and read-return outputs.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= ST_IDLE;
            rd_xact_q  <= 1'b0;
            owner_b_q  <= 1'b0;
            sd_rd      <= 1'b0;
            sd_wr      <= 1'b0;
            sd_refresh <= 1'b0;
            sd_addr    <= 23'd0;
            sd_din     <= 16'd0;
            sd_wdm     <= 2'd0;
            a_ack      <= 1'b0;
            b_ack      <= 1'b0;
            a_valid    <= 1'b0;
            b_valid    <= 1'b0;
            a_dout     <= 16'd0;
            b_dout     <= 16'd0;
        end else begin
            sd_rd      <= 1'b0;
            sd_wr      <= 1'b0;
            sd_refresh <= 1'b0;
            a_ack      <= 1'b0;
            b_ack      <= 1'b0;
            a_valid    <= 1'b0;
            b_valid    <= 1'b0;

            case (state_q)
                ST_IDLE: begin
                    if (sd_busy) begin
                        state_q <= ST_IDLE;
                    end else if (ref_req_s) begin
                        sd_refresh <= 1'b1;
                        rd_xact_q  <= 1'b0;
                        state_q    <= ST_CMD;
                    end else if (a_req) begin
                        sd_rd     <= 1'b1;
                        a_ack     <= 1'b1;
                        sd_addr   <= a_addr;
                        sd_din    <= 16'd0;
                        sd_wdm    <= 2'd0;
                        rd_xact_q <= 1'b1;
                        owner_b_q <= 1'b0;
                        state_q   <= ST_CMD;
                    end else if (b_req) begin
                        sd_wr     <= b_we;
                        sd_rd     <= ~b_we;
                        b_ack     <= 1'b1;
                        sd_addr   <= b_addr;
                        sd_din    <= b_din;
                        sd_wdm    <= b_wdm;
                        rd_xact_q <= ~b_we;
                        owner_b_q <= 1'b1;
                        state_q   <= ST_CMD;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_CMD: begin
                    state_q <= ST_WAIT_BUSY;
                end
                ST_WAIT_BUSY: begin
                    if (sd_busy) begin
                        state_q <= ST_WAIT_DONE;
                    end else begin
                        state_q <= ST_WAIT_BUSY;
                    end
                end
                ST_WAIT_DONE: begin
                    if (!sd_busy) begin
                        state_q <= ST_IDLE;
                    end else begin
                        state_q <= ST_WAIT_DONE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase

            // Read data is steered by the owner latched at grant, not by current requests.
            if (capture_s) begin
                if (owner_b_q) begin
                    b_dout  <= sd_dout;
                    b_valid <= 1'b1;
                end else begin
                    a_dout  <= sd_dout;
                    a_valid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed bench for sdram_arbiter with a small busy/latency controller model.
module tb_sdram_arbiter;

    logic        clk = 1'b0;
    logic        resetn;
    logic        a_req, a_ack, a_valid;
    logic [22:0] a_addr;
    logic [15:0] a_dout;
    logic        b_req, b_we, b_ack, b_valid;
    logic [22:0] b_addr;
    logic [15:0] b_din, b_dout;
    logic [1:0]  b_wdm;
    logic        sd_rd, sd_wr, sd_refresh;
    logic [22:0] sd_addr;
    logic [15:0] sd_din, sd_dout;
    logic [1:0]  sd_wdm;
    logic        sd_data_ready, sd_busy;

    always #5 clk = ~clk;

    sdram_arbiter dut (
        .clk(clk), .resetn(resetn),
        .a_req(a_req), .a_addr(a_addr), .a_ack(a_ack), .a_valid(a_valid), .a_dout(a_dout),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_din(b_din), .b_wdm(b_wdm),
        .b_ack(b_ack), .b_valid(b_valid), .b_dout(b_dout),
        .sd_rd(sd_rd), .sd_wr(sd_wr), .sd_refresh(sd_refresh), .sd_addr(sd_addr),
        .sd_din(sd_din), .sd_wdm(sd_wdm), .sd_dout(sd_dout),
        .sd_data_ready(sd_data_ready), .sd_busy(sd_busy)
    );

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;
    int rel_cyc = 0;

    // Controller model controls, driven by the stimulus process only.
    bit          mdl_force = 1'b0;
    logic [15:0] mdl_data = 16'h0000;

    // Model and monitor state, written only by the monitor process.
    int          mdl_cnt = 0;
    int          mdl_nrd = 0;
    bit          mdl_rd = 1'b0;
    int          a_ack_n, b_ack_n, a_val_n, b_val_n, rd_n, wr_n, ref_n, fall_n;
    int          a_ack_cyc, b_ack_cyc, wr_cyc, ready_cyc, a_val_cyc, fall_cyc;
    int          ref_cyc [4];
    logic [22:0] first_rd_addr, wr_addr;
    logic [15:0] wr_din;
    logic [1:0]  wr_wdm;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Monitor counts pulses at the negedge, then the model reacts to commands.
    initial begin
        sd_busy = 1'b0;
        sd_data_ready = 1'b0;
        sd_dout = 16'h0000;
        forever begin
            @(negedge clk);
            cyc++;
            if (!resetn) begin
                a_ack_n = 0; b_ack_n = 0; a_val_n = 0; b_val_n = 0;
                rd_n = 0; wr_n = 0; ref_n = 0; fall_n = 0;
                a_ack_cyc = 0; b_ack_cyc = 0; wr_cyc = 0; ready_cyc = 0;
                a_val_cyc = 0; fall_cyc = 0;
                for (int i = 0; i < 4; i++) ref_cyc[i] = 0;
                first_rd_addr = 23'd0;
            end else begin
                if (a_ack) begin a_ack_n++; a_ack_cyc = cyc; end
                if (b_ack) begin b_ack_n++; b_ack_cyc = cyc; end
                if (a_valid) begin a_val_n++; a_val_cyc = cyc; end
                if (b_valid) b_val_n++;
                if (sd_rd) begin
                    if (rd_n == 0) first_rd_addr = sd_addr;
                    rd_n++;
                end
                if (sd_wr) begin
                    wr_n++; wr_cyc = cyc;
                    wr_addr = sd_addr; wr_din = sd_din; wr_wdm = sd_wdm;
                end
                if (sd_refresh) begin
                    if (ref_n < 4) ref_cyc[ref_n] = cyc;
                    ref_n++;
                end
            end
            sd_data_ready = 1'b0;
            if (!resetn) begin
                mdl_cnt = 0;
                mdl_nrd = 0;
            end else if (sd_rd || sd_wr || sd_refresh) begin
                mdl_cnt = 1;
                mdl_rd = sd_rd;
                if (sd_rd) begin
                    sd_dout = mdl_data + 16'(mdl_nrd);
                    mdl_nrd++;
                end
            end else if (mdl_cnt > 0) begin
                mdl_cnt++;
                if (mdl_rd && mdl_cnt == 5) begin
                    sd_data_ready = 1'b1;
                    ready_cyc = cyc;
                end
                if (mdl_cnt == 6) begin
                    mdl_cnt = 0;
                    if (fall_n == 0) fall_cyc = cyc;
                    fall_n++;
                end
            end
            sd_busy = mdl_force | (mdl_cnt != 0);
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
        if (a_ack) a_req = 1'b0;
        if (b_ack) b_req = 1'b0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) step();
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        a_req = 1'b0;
        b_req = 1'b0;
        run(3);
        resetn = 1'b1;
        rel_cyc = cyc;
    endtask

    initial begin
        resetn = 1'b0;
        a_req = 1'b0; a_addr = 23'd0;
        b_req = 1'b0; b_we = 1'b0; b_addr = 23'd0; b_din = 16'd0; b_wdm = 2'd0;
        run(2);
        chk("rst_strobes", 32'({sd_rd, sd_wr, sd_refresh, a_ack, b_ack, a_valid, b_valid}), 32'h0);
        chk("rst_sd_bus", 32'({sd_addr, sd_din, sd_wdm}), 32'h0);
        chk("rst_douts", {a_dout, b_dout}, 32'h0);

        // Single port A read through the latency model.
        do_reset();
        mdl_data = 16'hBEEF;
        a_addr = 23'h000124;
        a_req = 1'b1;
        run(20);
        chk("rd_a_ack_n", 32'(a_ack_n), 32'd1);
        chk("rd_sd_rd_n", 32'(rd_n), 32'd1);
        chk("rd_sd_addr", 32'(first_rd_addr), 32'h00000124);
        chk("rd_a_valid_n", 32'(a_val_n), 32'd1);
        chk("rd_valid_lat", 32'(a_val_cyc - ready_cyc), 32'd1);
        chk("rd_a_dout", 32'(a_dout), 32'h0000BEEF);
        chk("rd_no_b_valid", 32'(b_val_n), 32'd0);
        chk("rd_no_wr_ref", 32'(wr_n + ref_n), 32'd0);

        // Single port B masked write.
        do_reset();
        b_we = 1'b1; b_addr = 23'h000003; b_din = 16'h12AB; b_wdm = 2'b10;
        b_req = 1'b1;
        run(20);
        chk("wr_sd_wr_n", 32'(wr_n), 32'd1);
        chk("wr_sd_addr", 32'(wr_addr), 32'h00000003);
        chk("wr_sd_din", 32'(wr_din), 32'h000012AB);
        chk("wr_sd_wdm", 32'(wr_wdm), 32'h00000002);
        chk("wr_b_ack_n", 32'(b_ack_n), 32'd1);
        chk("wr_no_b_valid", 32'(b_val_n), 32'd0);
        chk("wr_no_rd", 32'(rd_n), 32'd0);
        chk("wr_addr_held", 32'(sd_addr), 32'h00000003);

        // Simultaneous A read and B read: A first, data steered by owner.
        do_reset();
        mdl_data = 16'h1000;
        a_addr = 23'h000200;
        b_we = 1'b0; b_addr = 23'h000300;
        a_req = 1'b1;
        b_req = 1'b1;
        run(30);
        chk("ct_a_ack_n", 32'(a_ack_n), 32'd1);
        chk("ct_b_ack_n", 32'(b_ack_n), 32'd1);
        chk("ct_first_addr", 32'(first_rd_addr), 32'h00000200);
        chk("ct_a_before_b", 32'(b_ack_cyc > a_ack_cyc), 32'd1);
        chk("ct_b_grant_lat", 32'(b_ack_cyc - fall_cyc), 32'd2);
        chk("ct_a_dout", 32'(a_dout), 32'h00001000);
        chk("ct_b_dout", 32'(b_dout), 32'h00001001);
        chk("ct_valid_n", 32'({a_val_n[7:0], b_val_n[7:0]}), 32'h00000101);

        // Controller busy at start-up across two refresh wraps, with A waiting.
        mdl_force = 1'b1;
        do_reset();
        a_addr = 23'h000010;
        a_req = 1'b1;
        run(300);
        chk("su_no_cmd_300", 32'(rd_n + wr_n + ref_n + a_ack_n), 32'd0);
        wait_until(rel_cyc + 1700);
        chk("su_no_cmd_1700", 32'(rd_n + wr_n + ref_n + a_ack_n), 32'd0);
        mdl_force = 1'b0;
        run(40);
        chk("su_one_refresh", 32'(ref_n), 32'd1);
        chk("su_a_ack_n", 32'(a_ack_n), 32'd1);
        chk("su_ref_before_a", 32'(a_ack_cyc > ref_cyc[0]), 32'd1);

        // Idle refresh cadence, then a B write colliding with a wrap.
        do_reset();
        wait_until(rel_cyc + 2000);
        chk("rf_count", 32'(ref_n), 32'd2);
        chk("rf_first", 32'(ref_cyc[0] - rel_cyc), 32'd810);
        chk("rf_spacing", 32'(ref_cyc[1] - ref_cyc[0]), 32'd810);
        wait_until(rel_cyc + 2429);
        b_we = 1'b1; b_addr = 23'h000055; b_din = 16'h7777; b_wdm = 2'b00;
        b_req = 1'b1;
        run(30);
        chk("rf_wrap_ref", 32'(ref_cyc[2] - rel_cyc), 32'd2430);
        chk("rf_wr_n", 32'(wr_n), 32'd1);
        chk("rf_ref_before_wr", 32'(wr_cyc > ref_cyc[2]), 32'd1);
        chk("rf_b_ack_n", 32'(b_ack_n), 32'd1);

        // Reset asserted while a read waits in WAIT_DONE.
        do_reset();
        mdl_data = 16'h4321;
        a_addr = 23'h000124;
        a_req = 1'b1;
        begin
            int k;
            k = 0;
            while (mdl_cnt != 3 && k < 20) begin
                step();
                k++;
            end
            chk("rs_reach_wait", 32'(k < 20), 32'd1);
        end
        chk("rs_addr_before", 32'(sd_addr), 32'h00000124);
        resetn = 1'b0;
        #1;
        chk("rs_async_strobes", 32'({sd_rd, sd_wr, sd_refresh, a_ack, b_ack, a_valid, b_valid}), 32'h0);
        chk("rs_async_bus", 32'({sd_addr, sd_din, sd_wdm}), 32'h0);
        chk("rs_async_dout", {a_dout, b_dout}, 32'h0);
        run(2);
        resetn = 1'b1;
        run(20);
        chk("rs_no_valid", 32'(a_val_n + b_val_n), 32'd0);
        chk("rs_no_cmd", 32'(a_ack_n + rd_n), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
